fetch_sequencer: RTL and testbench

- Timepulse sequencer that sits directly upstream of the register bank (S, Z, G, SQ registers) and drives their write enables and shared write bus.
- Each accepted start runs one 12-timepulse instruction-fetch memory cycle: S <- Z, Z <- Z+1, memory read, G <- memory word, SQ <- G order code.
- Registers stay plain enable-gated flops; all sequencing lives here.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer_tp_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 32 +++
 tb/tb_fetch_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: timepulse schedule, widths and field helpers shared by the fetch sequencer.
package fetch_sequencer_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 12;
  localparam int TP_W = 4;
  localparam int TP_COUNT = 12;
  localparam int T_S = 1;
  localparam int T_Z = 2;
  localparam int T_RD = 4;
  localparam int T_G = 6;
  localparam int T_SQ = 7;
  localparam int SQ_HI = 14;
  localparam int SQ_LO = 12;
  typedef logic [TP_W-1:0] tp_t;
  typedef logic [WORD_W-1:0] word_t;
  function automatic logic [SQ_HI-SQ_LO:0] sq_field(input word_t w);
    return w[SQ_HI:SQ_LO];
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control inputs, register feedback and strobe/bus outputs of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;
  logic start;
  logic stall;
  word_t z_q;
  word_t g_q;
  word_t mem_rdata;
  tp_t tp;
  logic busy;
  logic done;
  logic mem_rd;
  word_t wbus;
  logic s_wren;
  logic z_wren;
  logic g_wren;
  logic sq_wren;
  modport master (
    output start, stall, z_q, g_q, mem_rdata,
    input tp, busy, done, mem_rd, wbus, s_wren, z_wren, g_wren, sq_wren
  );
  modport slave (
    input start, stall, z_q, g_q, mem_rdata,
    output tp, busy, done, mem_rd, wbus, s_wren, z_wren, g_wren, sq_wren
  );
endinterface

// File: rtl/fetch_sequencer_tp_counter.sv
// fetch_sequencer_tp_counter: idle/advance/stall/wrap timepulse counter; 0 is idle.
module fetch_sequencer_tp_counter
  import fetch_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stall,
  output tp_t  tp
);
  tp_t tp_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) tp <= '0;
    else tp <= tp_nxt;
  // the last timepulse chains straight into a new cycle when start is already up
  always_comb begin
    tp_nxt = tp;
    tp_nxt = (tp == '0) ? tp_t'(start) :
             stall ? tp :
             (tp == tp_t'(TP_COUNT)) ? tp_t'(start) : tp + tp_t'(1);
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: runs a 12-timepulse fetch (S<-Z, Z<-Z+1, read, G<-mem, SQ<-G) driving register enables and wbus.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input logic clk,
  input logic reset,
  fetch_sequencer_if.slave bus
);
  tp_t tp;
  logic adv;
  fetch_sequencer_tp_counter u_tp (
    .clk   (clk),
    .reset (reset),
    .start (bus.start),
    .stall (bus.stall),
    .tp    (tp)
  );
  // a strobe fires only on the cycle its timepulse advances, so stalls never repeat it
  assign adv = (tp != '0) && !bus.stall;
  assign bus.tp = tp;
  assign bus.busy = tp != '0;
  assign bus.done = adv && tp == tp_t'(TP_COUNT);
  assign bus.mem_rd = adv && tp == tp_t'(T_RD);
  assign bus.s_wren = adv && tp == tp_t'(T_S);
  assign bus.z_wren = adv && tp == tp_t'(T_Z);
  assign bus.g_wren = adv && tp == tp_t'(T_G);
  assign bus.sq_wren = adv && tp == tp_t'(T_SQ);
  assign bus.wbus = bus.s_wren ? bus.z_q :
                    bus.z_wren ? bus.z_q + word_t'(1) :
                    bus.g_wren ? bus.mem_rdata :
                    bus.sq_wren ? bus.g_q : '0;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed fetch scenarios against a timepulse-schedule model plus a behavioural register bank.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int m_tp = 0;
  int gcnt = 0;
  int swq[$];
  logic z_load = 0;
  word_t z_init = '0;
  word_t zr = '0, gr = '0;
  logic [ADDR_W-1:0] sr = '0;
  logic [2:0] sqr = '0;
  fetch_sequencer_if bus ();
  fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.z_q = zr;
  assign bus.g_q = gr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (z_load) zr <= z_init;
    else if (bus.z_wren) zr <= bus.wbus;
    if (bus.s_wren) sr <= bus.wbus[ADDR_W-1:0];
    if (bus.g_wren) gr <= bus.wbus;
    if (bus.sq_wren) sqr <= sq_field(bus.wbus);
  end
  // model: which timepulse the memory cycle is on, from start/stall rules
  always @(posedge clk or posedge reset)
    if (reset) m_tp <= 0;
    else if (m_tp == 0) m_tp <= bus.start ? 1 : 0;
    else if (!bus.stall) m_tp <= (m_tp == TP_COUNT) ? (bus.start ? 1 : 0) : m_tp + 1;
  always @(negedge clk) begin
    logic fire, es, ez, eg, esq;
    word_t ew;
    fire = m_tp != 0 && !bus.stall;
    es = fire && m_tp == T_S;
    ez = fire && m_tp == T_Z;
    eg = fire && m_tp == T_G;
    esq = fire && m_tp == T_SQ;
    ew = es ? bus.z_q : ez ? word_t'(bus.z_q + 1) : eg ? bus.mem_rdata : esq ? bus.g_q : 16'h0;
    chk("tp", bus.tp, m_tp);
    chk("busy", bus.busy, m_tp != 0);
    chk("done", bus.done, fire && m_tp == TP_COUNT);
    chk("mem_rd", bus.mem_rd, fire && m_tp == T_RD);
    chk("s_wren", bus.s_wren, es);
    chk("z_wren", bus.z_wren, ez);
    chk("g_wren", bus.g_wren, eg);
    chk("sq_wren", bus.sq_wren, esq);
    chk("wbus", bus.wbus, ew);
    chk("onehot", $countones({bus.s_wren, bus.z_wren, bus.g_wren, bus.sq_wren}) <= 1, 1);
    if (bus.s_wren) swq.push_back(cyc);
    if (bus.g_wren) gcnt++;
  end
  task automatic load_z(input word_t v);
    z_init = v;
    z_load = 1;
    step();
    z_load = 0;
  endtask
  task automatic run_fetch(input int stall_tp, input int stall_len, input int pulse_tp, output int lat);
    int n = 0;
    int st = 0;
    lat = -1;
    bus.start = 1;
    while (n < 40 && lat < 0) begin
      step();
      n++;
      bus.start = (pulse_tp != 0 && int'(bus.tp) == pulse_tp);
      if (stall_tp != 0 && int'(bus.tp) == stall_tp && st < stall_len) begin
        bus.stall = 1;
        st++;
      end else bus.stall = 0;
      if (bus.done) lat = n + 1;
    end
    bus.start = 0;
    bus.stall = 0;
    chk("fetch_timeout", lat > 0, 1);
  endtask
  initial begin
    int lat;
    int nd;
    int prev;
    bus.start = 0;
    bus.stall = 0;
    bus.mem_rdata = '0;
    step();
    step();
    chk("reset_tp", bus.tp, 0);
    chk("reset_busy", bus.busy, 0);
    reset = 0;
    step();
    // reset mid-run at tp=5
    load_z(16'h0010);
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 10 && bus.tp != 4'd5; i++) step();
    chk("mid_tp5", bus.tp, 5);
    reset = 1;
    #1;
    chk("mid_rst_tp", bus.tp, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_strobes", {bus.s_wren, bus.z_wren, bus.g_wren, bus.sq_wren, bus.mem_rd, bus.done}, 0);
    chk("mid_rst_wbus", bus.wbus, 0);
    step();
    reset = 0;
    step();
    step();
    step();
    chk("mid_idle_tp", bus.tp, 0);
    chk("mid_z_kept", zr, 16'h0011);
    // single fetch
    load_z(16'h0100);
    bus.mem_rdata = 16'h3ABC;
    run_fetch(0, 0, 0, lat);
    chk("single_lat", lat, 13);
    step();
    chk("single_s", sr, 12'h100);
    chk("single_z", zr, 16'h0101);
    chk("single_g", gr, 16'h3ABC);
    chk("single_sq", sqr, 3);
    chk("single_idle", bus.tp, 0);
    // Z wrap
    load_z(16'hFFFF);
    bus.mem_rdata = 16'h5123;
    run_fetch(0, 0, 0, lat);
    step();
    chk("wrap_s", sr, 12'hFFF);
    chk("wrap_z", zr, 16'h0000);
    chk("wrap_sq", sqr, 5);
    // stall at tp6 for 3 clocks
    load_z(16'h0400);
    bus.mem_rdata = 16'h1234;
    gcnt = 0;
    run_fetch(T_G, 3, 0, lat);
    step();
    chk("stall_lat", lat, 16);
    chk("stall_gcnt", gcnt, 1);
    chk("stall_g", gr, 16'h1234);
    // back-to-back with start held through tp12
    load_z(16'h0200);
    swq.delete();
    bus.start = 1;
    nd = 0;
    prev = 0;
    for (int n = 0; n < 60 && nd < 2; n++) begin
      step();
      if (prev != 0) begin
        chk("b2b_tp1", bus.tp, 1);
        bus.start = 0;
      end
      prev = int'(bus.done);
      if (bus.done) nd++;
    end
    bus.start = 0;
    chk("b2b_two_done", nd, 2);
    step();
    chk("b2b_swq", swq.size(), 2);
    if (swq.size() == 2) chk("b2b_gap", swq[1] - swq[0], 12);
    chk("b2b_z", zr, 16'h0202);
    chk("b2b_idle", bus.tp, 0);
    // start pulsed at tp3 is not queued
    swq.delete();
    run_fetch(0, 0, 3, lat);
    chk("pulse_lat", lat, 13);
    step();
    chk("pulse_idle", bus.tp, 0);
    step();
    step();
    chk("pulse_still_idle", bus.tp, 0);
    chk("pulse_one_s", swq.size(), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
